// File: rtl/jtkcpu_intctrl_pkg.sv
// Shared KCPU interrupt definitions: vector nibbles, sequencer states and
// condition-code bit positions.
package jtkcpu_intctrl_pkg;

  localparam logic [3:0] VEC_NMI  = 4'hC;
  localparam logic [3:0] VEC_FIRQ = 4'h6;
  localparam logic [3:0] VEC_IRQ  = 4'h8;

  localparam int CC_Z = 2;
  localparam int CC_I = 4;
  localparam int CC_F = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_WAIT_S = 3'd2,
    ST_WAIT_C = 3'd3,
    ST_HALT   = 3'd4
  } int_state_e;

  // Fixed priority NMI > FIRQ > IRQ; only meaningful when something is pending
  function automatic logic [3:0] pick_vec(input logic nmi, input logic firq);
    if (nmi) begin
      return VEC_NMI;
    end else if (firq) begin
      return VEC_FIRQ;
    end else begin
      return VEC_IRQ;
    end
  endfunction

endpackage

// File: rtl/jtkcpu_pinsync.sv
// cen-qualified multi-stage synchroniser for one asynchronous pin; resets to
// the pin's deasserted level.
module jtkcpu_pinsync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_r;

  // Shift chain, advancing only on enabled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{RST_VAL}};
    end else if (cen) begin
      sync_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/jtkcpu_intctrl.sv
// KCPU interrupt/halt sequencer: synchronises the pins, latches NMI edges and
// hands one masked, prioritised request at a time to the microcode.
module jtkcpu_intctrl
  import jtkcpu_intctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       nmi_n,
  input  logic       firq_n,
  input  logic       irq_n,
  input  logic       halt,
  input  logic [7:0] cc,
  input  logic       nmi_arm,
  input  logic       boundary,
  input  logic       wait_sync,
  input  logic       wait_cwai,
  input  logic       ack,
  output logic       intsrv,
  output logic [3:0] intvec,
  output logic       full_stk,
  output logic       stacked,
  output logic       resume,
  output logic       halted
);

  logic nmi_s, firq_s, irq_s, halt_s;
  logic nmi_last_r, nmi_armed_r, nmi_pend_r;
  logic nmi_edge_s, firq_pend_s, irq_pend_s, any_pend_s, any_line_s;
  logic [3:0] vec_s;
  int_state_e state_r;
  logic unused_cc_s;

  jtkcpu_pinsync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nmi (
    .clk(clk), .rst(rst), .cen(cen), .din(nmi_n),  .dout(nmi_s));
  jtkcpu_pinsync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_firq (
    .clk(clk), .rst(rst), .cen(cen), .din(firq_n), .dout(firq_s));
  jtkcpu_pinsync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_irq (
    .clk(clk), .rst(rst), .cen(cen), .din(irq_n),  .dout(irq_s));
  jtkcpu_pinsync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_halt (
    .clk(clk), .rst(rst), .cen(cen), .din(halt),   .dout(halt_s));

  assign nmi_edge_s  = nmi_armed_r & nmi_last_r & ~nmi_s;
  assign firq_pend_s = ~firq_s & ~cc[CC_F];
  assign irq_pend_s  = ~irq_s & ~cc[CC_I];
  assign any_pend_s  = nmi_pend_r | firq_pend_s | irq_pend_s;
  // SYNC wakes on any raw line, masked or not
  assign any_line_s  = ~nmi_s | ~firq_s | ~irq_s;
  assign vec_s       = pick_vec(nmi_pend_r, firq_pend_s);
  assign unused_cc_s = ^{cc[7], cc[5], cc[3:0]};

  // NMI arming and edge latch; a fresh edge beats the clear from its own ack
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_last_r  <= 1'b1;
      nmi_armed_r <= 1'b0;
      nmi_pend_r  <= 1'b0;
    end else if (cen) begin
      nmi_last_r  <= nmi_s;
      nmi_armed_r <= nmi_armed_r | nmi_arm;
      if (nmi_edge_s) begin
        nmi_pend_r <= 1'b1;
      end else if (state_r == ST_SERVE && ack && intvec == VEC_NMI) begin
        nmi_pend_r <= 1'b0;
      end
    end
  end

  // Sequencer state and registered microcode handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      intsrv   <= 1'b0;
      intvec   <= 4'h0;
      full_stk <= 1'b0;
      stacked  <= 1'b0;
      resume   <= 1'b0;
      halted   <= 1'b0;
    end else if (cen) begin
      resume <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (wait_sync) begin
            state_r <= ST_WAIT_S;
          end else if (wait_cwai) begin
            state_r <= ST_WAIT_C;
          end else if (boundary && halt_s) begin
            state_r <= ST_HALT;
            halted  <= 1'b1;
          end else if (boundary && any_pend_s) begin
            state_r  <= ST_SERVE;
            intsrv   <= 1'b1;
            intvec   <= vec_s;
            full_stk <= (vec_s != VEC_FIRQ);
            stacked  <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (ack) begin
            state_r <= ST_IDLE;
            intsrv  <= 1'b0;
          end
        end
        ST_WAIT_S: begin
          if (any_pend_s) begin
            state_r  <= ST_SERVE;
            intsrv   <= 1'b1;
            intvec   <= vec_s;
            full_stk <= (vec_s != VEC_FIRQ);
            stacked  <= 1'b0;
          end else if (any_line_s) begin
            state_r <= ST_IDLE;
            resume  <= 1'b1;
          end
        end
        ST_WAIT_C: begin
          if (any_pend_s) begin
            state_r  <= ST_SERVE;
            intsrv   <= 1'b1;
            intvec   <= vec_s;
            full_stk <= (vec_s != VEC_FIRQ);
            stacked  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!halt_s) begin
            state_r <= ST_IDLE;
            halted  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          intsrv  <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/jtkcpu_intctrl.md
Name: jtkcpu_intctrl

Overview:
- Interrupt and halt sequencer for the KCPU core.
- Synchronises NMI/FIRQ/IRQ/HALT pins, latches the NMI edge and applies CC masks.
- Arbitrates by priority and hands one request at a time to the microcode at instruction boundaries; handles SYNC/CWAI wait states.
- Drives the intsrv/intvec pair consumed by the microcode sequencer and PC logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each asynchronous pin (1..3); adds SYNC_STAGES cen-cycles of pin latency

Ports:
clk        input   1  clock
rst        input   1  synchronous reset, active-high
cen        input   1  clock enable; all state advances only when high
nmi_n      input   1  NMI pin, falling-edge sensitive
firq_n     input   1  FIRQ pin, level, active-low
irq_n      input   1  IRQ pin, level, active-low
halt       input   1  halt request, level, active-high
cc         input   8  condition codes; bit6 = F mask, bit4 = I mask
nmi_arm    input   1  pulse: S register loaded; enables NMI
boundary   input   1  microcode at instruction boundary (fetch slot)
wait_sync  input   1  pulse: SYNC executed
wait_cwai  input   1  pulse: CWAI executed (registers already stacked)
ack        input   1  microcode finished vector fetch for the current request
intsrv     output  1  interrupt service request to microcode
intvec     output  4  vector low nibble: C=NMI, 6=FIRQ, 8=IRQ
full_stk   output  1  1 = stack entire state (NMI/IRQ), 0 = PC+CC only (FIRQ)
stacked    output  1  registers already pushed (CWAI path); microcode skips push
resume     output  1  one-cen pulse: SYNC released by a masked line; continue without service
halted     output  1  core halted; bus idle

Behaviour:
- Reset: all outputs 0, state IDLE, nmi_pend=0, NMI disarmed, sync flops = pins deasserted.
- Sync: each pin passes through SYNC_STAGES flops clocked on cen.
- NMI edge: synced nmi_n 1->0 while armed sets nmi_pend. Edges before arming are lost. nmi_arm is sticky until rst.
- Pending set: nmi_pend; firq = !firq_s & !cc[6]; irq = !irq_s & !cc[4].
- Priority: NMI > FIRQ > IRQ.
- States IDLE, SERVE, WAIT_S, WAIT_C, HALT.
- IDLE, boundary=1 (checked in this order):
  - halt_s -> HALT, halted=1 on the next cen.
  - any pending -> SERVE; latch intvec, full_stk, stacked=0; intsrv=1 from the next cen.
  - Otherwise stay in IDLE.
- IDLE, boundary=0: ignore halt and interrupts.
- IDLE, wait_sync -> WAIT_S. IDLE, wait_cwai -> WAIT_C. If wait_sync/wait_cwai coincide with boundary, the wait pulse wins.
- SERVE:
  - intvec, full_stk and stacked are frozen; a higher-priority arrival is not preempting.
  - On ack: intsrv=0, go to IDLE, and clear nmi_pend if the latched vector was NMI.
  - A new NMI edge during SERVE of NMI stays pending.
  - Level lines are not latched; if the line is released before boundary, no request is made.
- WAIT_S, any synced line asserted (masks ignored):
  - If pending (masked test) -> SERVE, stacked=0.
  - Else resume=1 for one cen -> IDLE.
- WAIT_C: remain until pending -> SERVE with stacked=1. Masked lines do not wake CWAI.
- HALT: halted=1; exit when halt_s=0 -> IDLE on the same cen, halted=0. Interrupts accumulate but are not serviced while halted.
- cen=0: outputs and state hold. Pulses (resume) last exactly one cen-qualified cycle.
- rst mid-operation: immediate return to reset values. A pending NMI is discarded and NMI is disarmed.
- ack outside SERVE is ignored.

Decomposition:
- Shared package jtkcpu.inc adds:
  - vector constants VEC_NMI=4'hC, VEC_FIRQ=4'h6, VEC_IRQ=4'h8
  - state encodings for IDLE, SERVE, WAIT_S, WAIT_C, HALT
  - CC_F and CC_I bit indices alongside the existing CC_Z
- Sub-module jtkcpu_pinsync: SYNC_STAGES-deep cen-qualified synchroniser, instanced for the four pins.

Test Plan:
- Pre-arm NMI: nmi_n falls before nmi_arm, then boundary -> intsrv stays 0. After nmi_arm plus a new edge, then boundary -> intsrv=1, intvec=C, full_stk=1; ack -> intsrv=0 and nmi_pend cleared.
- Priority: firq_n=0, irq_n=0, cc=0, boundary -> intvec=6, full_stk=0. Assert NMI edge during SERVE -> vector stays 6. After ack and the next boundary -> intvec=C.
- Masks: irq_n=0 with cc[4]=1 and boundary -> no intsrv. Clear cc[4] -> intsrv at the next boundary, SYNC_STAGES+1 cen after the pin when already low.
- SYNC: wait_sync, then irq_n=0 with cc[4]=1 -> resume pulses once, state IDLE, intsrv=0. Repeat with cc[4]=0 -> intsrv=1, stacked=0.
- CWAI: wait_cwai with cc[6]=1, firq_n=0 -> stays waiting. Then irq_n=0, cc[4]=0 -> intsrv=1, intvec=8, stacked=1.
- Halt/cen/reset: halt=1 with boundary=0 -> no halt; boundary=1 -> halted=1. Hold cen=0 -> no change. Assert rst mid-SERVE -> all outputs 0 on the next clk.
